// File: rtl/pong_game_fsm.sv
// Pong game controller: new game / play / new ball / game over sequencing with BCD score and lives.
// Optional feature: define SCORE_SATURATE_EN to hold the score at 99 instead of wrapping to 00.
module pong_game_fsm #(
  parameter int unsigned LIVES = 3
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] btn,
  input  logic       hit,
  input  logic       miss,
  input  logic       timer_up,
  output logic       timer_start,
  output logic       graph_still,
  output logic       game_over,
  output logic [1:0] state,
  output logic [7:0] score,
  output logic [1:0] lives
);

  typedef enum logic [1:0] {
    NEWGAME = 2'b00,
    PLAY    = 2'b01,
    NEWBALL = 2'b10,
    OVER    = 2'b11
  } state_t;

  localparam logic [1:0] LIVES_INIT = 2'(LIVES);

  state_t cur;
  logic   any_now;
  logic   any_prev;
  logic   armed;
  logic   press;

  // BCD increment of a two-digit score; wraps or saturates at 99.
  function automatic logic [7:0] bcd_inc(input logic [7:0] s);
    logic [7:0] r;
    r = s;
    if (s == 8'h99) begin
`ifdef SCORE_SATURATE_EN
      r = 8'h99;
`else
      r = 8'h00;
`endif
    end else if (s[3:0] == 4'd9) begin
      r = {s[7:4] + 4'd1, 4'd0};
    end else begin
      r = {s[7:4], s[3:0] + 4'd1};
    end
    return r;
  endfunction

  assign any_now = (btn != 2'b00);
  // armed stays low until the buttons are seen released after reset, so a button
  // held through reset release cannot start a game.
  assign press   = any_now & ~any_prev & armed;

  assign state       = cur;
  assign timer_start = (cur == PLAY) & miss;

  // Game state machine with registered status outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cur         <= NEWGAME;
      score       <= 8'h00;
      lives       <= LIVES_INIT;
      any_prev    <= 1'b0;
      armed       <= 1'b0;
      graph_still <= 1'b1;
      game_over   <= 1'b0;
    end else begin
      any_prev <= any_now;
      armed    <= armed | ~any_now;
      case (cur)
        NEWGAME: begin
          if (press) begin
            cur         <= PLAY;
            graph_still <= 1'b0;
          end
        end
        PLAY: begin
          if (miss) begin
            graph_still <= 1'b1;
            if (lives == 2'd1) begin
              lives     <= 2'd0;
              cur       <= OVER;
              game_over <= 1'b1;
            end else begin
              lives <= lives - 2'd1;
              cur   <= NEWBALL;
            end
          end else if (hit) begin
            score <= bcd_inc(score);
          end
        end
        NEWBALL: begin
          if (timer_up && press) begin
            cur         <= PLAY;
            graph_still <= 1'b0;
          end
        end
        OVER: begin
          if (timer_up) begin
            cur       <= NEWGAME;
            score     <= 8'h00;
            lives     <= LIVES_INIT;
            game_over <= 1'b0;
          end
        end
        default: begin
          cur         <= NEWGAME;
          score       <= 8'h00;
          lives       <= LIVES_INIT;
          graph_still <= 1'b1;
          game_over   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pong_game_fsm.sv
// Self-checking bench for pong_game_fsm: vector table plus hand sequences, checked through a scoreboard queue.
module tb_pong_game_fsm;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [1:0] btn;
  logic       hit, miss, timer_up;
  logic       timer_start, graph_still, game_over;
  logic [1:0] state;
  logic [7:0] score;
  logic [1:0] lives;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [1:0] btn;
    logic       hit;
    logic       miss;
    logic       tup;
    logic [1:0] st;
    logic [7:0] sc;
    logic [1:0] lv;
    logic       ts;
  } vec_t;

  vec_t sb[$];
  vec_t tbl[19];
  logic ts_seen;

  pong_game_fsm #(.LIVES(3)) dut (
    .clk(clk), .reset_n(reset_n), .btn(btn), .hit(hit), .miss(miss),
    .timer_up(timer_up), .timer_start(timer_start), .graph_still(graph_still),
    .game_over(game_over), .state(state), .score(score), .lives(lives)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic [1:0] b, input logic h, input logic m, input logic t,
                              input logic [1:0] st, input logic [7:0] sc, input logic [1:0] lv,
                              input logic ts);
    vec_t v;
    v.btn = b; v.hit = h; v.miss = m; v.tup = t;
    v.st = st; v.sc = sc; v.lv = lv; v.ts = ts;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic apply(input vec_t v, input string nm);
    vec_t e;
    sb.push_back(v);
    btn = v.btn; hit = v.hit; miss = v.miss; timer_up = v.tup;
    #1 ts_seen = timer_start;
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk({nm, "/timer_start"}, {7'd0, ts_seen}, {7'd0, e.ts});
    chk({nm, "/state"}, {6'd0, state}, {6'd0, e.st});
    chk({nm, "/score"}, score, e.sc);
    chk({nm, "/lives"}, {6'd0, lives}, {6'd0, e.lv});
    chk({nm, "/graph_still"}, {7'd0, graph_still}, {7'd0, (e.st != 2'b01)});
    chk({nm, "/game_over"}, {7'd0, game_over}, {7'd0, (e.st == 2'b11)});
  endtask

  function automatic logic [7:0] to_bcd(input int n);
    logic [3:0] t, u;
    t = 4'(n / 10);
    u = 4'(n % 10);
    return {t, u};
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    //             btn    h     m     tup   st     score  lv    ts
    tbl[0]  = mk(2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 8'h00, 2'd3, 1'b0);
    tbl[1]  = mk(2'b01, 1'b0, 1'b0, 1'b0, 2'b01, 8'h00, 2'd3, 1'b0);
    tbl[2]  = mk(2'b01, 1'b1, 1'b0, 1'b0, 2'b01, 8'h01, 2'd3, 1'b0);
    tbl[3]  = mk(2'b00, 1'b1, 1'b0, 1'b0, 2'b01, 8'h02, 2'd3, 1'b0);
    tbl[4]  = mk(2'b00, 1'b1, 1'b1, 1'b0, 2'b10, 8'h02, 2'd2, 1'b1);
    tbl[5]  = mk(2'b01, 1'b0, 1'b0, 1'b0, 2'b10, 8'h02, 2'd2, 1'b0);
    tbl[6]  = mk(2'b00, 1'b0, 1'b0, 1'b0, 2'b10, 8'h02, 2'd2, 1'b0);
    tbl[7]  = mk(2'b10, 1'b0, 1'b0, 1'b1, 2'b01, 8'h02, 2'd2, 1'b0);
    tbl[8]  = mk(2'b00, 1'b1, 1'b0, 1'b0, 2'b01, 8'h03, 2'd2, 1'b0);
    tbl[9]  = mk(2'b00, 1'b0, 1'b1, 1'b0, 2'b10, 8'h03, 2'd1, 1'b1);
    tbl[10] = mk(2'b00, 1'b0, 1'b0, 1'b1, 2'b10, 8'h03, 2'd1, 1'b0);
    tbl[11] = mk(2'b11, 1'b0, 1'b0, 1'b1, 2'b01, 8'h03, 2'd1, 1'b0);
    tbl[12] = mk(2'b11, 1'b1, 1'b0, 1'b0, 2'b01, 8'h04, 2'd1, 1'b0);
    tbl[13] = mk(2'b00, 1'b0, 1'b1, 1'b0, 2'b11, 8'h04, 2'd0, 1'b1);
    tbl[14] = mk(2'b00, 1'b1, 1'b0, 1'b0, 2'b11, 8'h04, 2'd0, 1'b0);
    tbl[15] = mk(2'b01, 1'b0, 1'b1, 1'b0, 2'b11, 8'h04, 2'd0, 1'b0);
    tbl[16] = mk(2'b00, 1'b0, 1'b0, 1'b1, 2'b00, 8'h00, 2'd3, 1'b0);
    tbl[17] = mk(2'b00, 1'b1, 1'b1, 1'b0, 2'b00, 8'h00, 2'd3, 1'b0);
    tbl[18] = mk(2'b01, 1'b0, 1'b0, 1'b0, 2'b01, 8'h00, 2'd3, 1'b0);

    reset_n = 1'b0; btn = 2'b00; hit = 1'b0; miss = 1'b0; timer_up = 1'b0;
    #12;
    chk("reset/state", {6'd0, state}, 8'h00);
    chk("reset/score", score, 8'h00);
    chk("reset/lives", {6'd0, lives}, 8'h03);
    chk("reset/graph_still", {7'd0, graph_still}, 8'h01);
    chk("reset/game_over", {7'd0, game_over}, 8'h00);
    chk("reset/timer_start", {7'd0, timer_start}, 8'h00);
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < 19; i++) apply(tbl[i], $sformatf("vec%0d", i));

    // 100 hits from score 00: 99 reaches 8'h99, the 100th wraps or saturates
    for (int i = 1; i <= 100; i++) begin
      n = i;
      if (n > 99) begin
`ifdef SCORE_SATURATE_EN
        n = 99;
`else
        n = 0;
`endif
      end
      apply(mk(2'b00, 1'b1, 1'b0, 1'b0, 2'b01, to_bcd(n), 2'd3, 1'b0), $sformatf("hit%0d", i));
    end

    // Asynchronous reset mid-game, button held through release
    #2;
    btn = 2'b01; miss = 1'b1; hit = 1'b0;
    reset_n = 1'b0;
    #1;
    chk("async_rst/state", {6'd0, state}, 8'h00);
    chk("async_rst/score", score, 8'h00);
    chk("async_rst/lives", {6'd0, lives}, 8'h03);
    chk("async_rst/graph_still", {7'd0, graph_still}, 8'h01);
    chk("async_rst/timer_start", {7'd0, timer_start}, 8'h00);
    @(negedge clk);
    reset_n = 1'b1;
    apply(mk(2'b01, 1'b0, 1'b0, 1'b0, 2'b00, 8'h00, 2'd3, 1'b0), "held0");
    apply(mk(2'b01, 1'b0, 1'b0, 1'b0, 2'b00, 8'h00, 2'd3, 1'b0), "held1");
    apply(mk(2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 8'h00, 2'd3, 1'b0), "released");
    apply(mk(2'b01, 1'b0, 1'b0, 1'b0, 2'b01, 8'h00, 2'd3, 1'b0), "repress");
    for (int i = 1; i <= 5; i++)
      apply(mk(2'b00, 1'b1, 1'b0, 1'b0, 2'b01, to_bcd(i), 2'd3, 1'b0), $sformatf("hitb%0d", i));
    apply(mk(2'b00, 1'b0, 1'b1, 1'b0, 2'b10, 8'h05, 2'd2, 1'b1), "miss_b");
    apply(mk(2'b00, 1'b0, 1'b0, 1'b1, 2'b10, 8'h05, 2'd2, 1'b0), "tup_nopress");
    apply(mk(2'b01, 1'b0, 1'b0, 1'b1, 2'b01, 8'h05, 2'd2, 1'b0), "resume");
    apply(mk(2'b01, 1'b1, 1'b1, 1'b0, 2'b10, 8'h05, 2'd1, 1'b1), "hit_and_miss");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
